// File: rtl/bfm_apbtoahb_pkg.sv
// Shared AHB encodings and bridge state codes for the APB3 -> AHB-Lite bridge.
package bfm_apbtoahb_pkg;

  // AHB-Lite control encodings driven by the bridge
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DATA    = 4'b0011;

  // Bridge state encodings (3-bit, legacy-compatible)
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ADDR = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_ERR  = 3'd3;
  localparam logic [2:0] ST_RESP = 3'd4;

  // Mask selecting the PADDR bits forwarded to HADDR; the rest come from the base
  function automatic logic [31:0] addr_mask(input int unsigned width);
    if (width >= 32'd32) begin
      addr_mask = 32'hFFFF_FFFF;
    end else begin
      addr_mask = (32'h0000_0001 << width) - 32'h0000_0001;
    end
  endfunction

endpackage

// File: rtl/bfm_apbtoahb.sv
// APB3 slave to AHB-Lite master bridge: every APB access becomes one AHB
// SINGLE word transfer; read data and error status return on PRDATA/PSLVERR.
// All outputs come straight from flops; TPD is kept only for interface
// compatibility with the BFM environment and has no effect on the logic.
module bfm_apbtoahb
  import bfm_apbtoahb_pkg::*;
#(
  parameter int          TPD        = 1,
  parameter int          ADDR_WIDTH = 24,
  parameter logic [31:0] AHB_BASE   = 32'h0000_0000
) (
  input  logic        HCLK,
  input  logic        HRESETN,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic        HMASTLOCK,
  output logic [3:0]  HPROT,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  localparam logic [31:0] ADDR_MASK = addr_mask(ADDR_WIDTH);
  localparam logic [31:0] TPD_BITS  = 32'(TPD);

  logic [2:0]  state_q,   state_d;
  logic [31:0] haddr_q,   haddr_d;
  logic        hwrite_q,  hwrite_d;
  logic [1:0]  htrans_q,  htrans_d;
  logic [31:0] hwdata_q,  hwdata_d;
  logic [31:0] wdata_q,   wdata_d;
  logic [31:0] prdata_q,  prdata_d;
  logic        pready_q,  pready_d;
  logic        pslverr_q, pslverr_d;
  logic        unused_s;

  // Next-state and next-output computation for the bridge FSM
  always_comb begin
    state_d   = state_q;
    haddr_d   = haddr_q;
    hwrite_d  = hwrite_q;
    htrans_d  = htrans_q;
    hwdata_d  = hwdata_q;
    wdata_d   = wdata_q;
    prdata_d  = prdata_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Only the APB setup phase starts a transfer
        if (PSEL && !PENABLE) begin
          haddr_d  = (AHB_BASE & ~ADDR_MASK) | (PADDR & ADDR_MASK);
          hwrite_d = PWRITE;
          wdata_d  = PWDATA;
          htrans_d = HTRANS_NONSEQ;
          state_d  = ST_ADDR;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_ADDR: begin
        // Address phase accepted: present write data in the following data phase
        if (HREADY) begin
          htrans_d = HTRANS_IDLE;
          hwdata_d = wdata_q;
          state_d  = ST_DATA;
        end else begin
          state_d  = ST_ADDR;
        end
      end
      ST_DATA: begin
        if (HREADY && !HRESP) begin
          if (!hwrite_q) begin
            prdata_d = HRDATA;
          end else begin
            prdata_d = prdata_q;
          end
          pready_d  = 1'b1;
          pslverr_d = 1'b0;
          state_d   = ST_RESP;
        end else if (HREADY && HRESP) begin
          // Malformed one-cycle error from the slave still reported as an error
          pready_d  = 1'b1;
          pslverr_d = 1'b1;
          state_d   = ST_RESP;
        end else if (HRESP) begin
          state_d   = ST_ERR;
        end else begin
          state_d   = ST_DATA;
        end
      end
      ST_ERR: begin
        // Second cycle of the two-cycle ERROR response ends the transfer
        if (HREADY && HRESP) begin
          pready_d  = 1'b1;
          pslverr_d = 1'b1;
          state_d   = ST_RESP;
        end else begin
          state_d   = ST_ERR;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        htrans_d = HTRANS_IDLE;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously by HRESETN
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state_q   <= ST_IDLE;
      haddr_q   <= 32'h0000_0000;
      hwrite_q  <= 1'b0;
      htrans_q  <= HTRANS_IDLE;
      hwdata_q  <= 32'h0000_0000;
      wdata_q   <= 32'h0000_0000;
      prdata_q  <= 32'h0000_0000;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      haddr_q   <= haddr_d;
      hwrite_q  <= hwrite_d;
      htrans_q  <= htrans_d;
      hwdata_q  <= hwdata_d;
      wdata_q   <= wdata_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
    end
  end

  assign PRDATA    = prdata_q;
  assign PREADY    = pready_q;
  assign PSLVERR   = pslverr_q;
  assign HADDR     = haddr_q;
  assign HTRANS    = htrans_q;
  assign HWRITE    = hwrite_q;
  assign HWDATA    = hwdata_q;
  assign HSIZE     = HSIZE_WORD;
  assign HBURST    = HBURST_SINGLE;
  assign HMASTLOCK = 1'b0;
  assign HPROT     = HPROT_DATA;

  // PADDR bits above ADDR_WIDTH and TPD intentionally have no effect
  assign unused_s  = ^{TPD_BITS, PADDR};

endmodule

// File: tb/tb_bfm_apbtoahb.sv
// Directed bench for bfm_apbtoahb: the bench acts as APB master and AHB slave,
// expected APB responses are queued at setup and popped on PREADY.
module tb_bfm_apbtoahb;

  logic        HCLK    = 1'b0;
  logic        HRESETN = 1'b0;
  logic        PSEL    = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PWRITE  = 1'b0;
  logic [31:0] PADDR   = 32'h0;
  logic [31:0] PWDATA  = 32'h0;
  logic [31:0] HRDATA  = 32'h0;
  logic        HREADY  = 1'b1;
  logic        HRESP   = 1'b0;

  logic [31:0] PRDATA, HADDR, HWDATA;
  logic        PREADY, PSLVERR, HWRITE, HMASTLOCK;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;

  logic [31:0] PRDATA_B, HADDR_B, HWDATA_B;
  logic        PREADY_B, PSLVERR_B, HWRITE_B, HMASTLOCK_B;
  logic [1:0]  HTRANS_B;
  logic [2:0]  HSIZE_B, HBURST_B;
  logic [3:0]  HPROT_B;

  typedef struct packed {
    logic [31:0] prdata;
    logic        pslverr;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model_prdata = 32'h0;
  int          n_assert = 0;
  int          n_fail   = 0;

  always #5 HCLK = ~HCLK;

  bfm_apbtoahb dut (
    .HCLK(HCLK), .HRESETN(HRESETN), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HMASTLOCK(HMASTLOCK), .HPROT(HPROT), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADY(HREADY), .HRESP(HRESP)
  );

  bfm_apbtoahb #(.ADDR_WIDTH(24), .AHB_BASE(32'h2000_0000)) dut_b (
    .HCLK(HCLK), .HRESETN(HRESETN), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA_B), .PREADY(PREADY_B), .PSLVERR(PSLVERR_B),
    .HADDR(HADDR_B), .HTRANS(HTRANS_B), .HWRITE(HWRITE_B), .HSIZE(HSIZE_B), .HBURST(HBURST_B),
    .HMASTLOCK(HMASTLOCK_B), .HPROT(HPROT_B), .HWDATA(HWDATA_B), .HRDATA(HRDATA),
    .HREADY(HREADY), .HRESP(HRESP)
  );

  function automatic logic [31:0] exp_haddr(input logic [31:0] base, input logic [31:0] paddr);
    exp_haddr = {base[31:24], paddr[23:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One APB access with the bench answering as AHB slave.
  // waits: data-phase wait states; err: two-cycle ERROR; drop: PSEL released after setup.
  task automatic apb_access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input int waits, input logic err, input logic [31:0] rdata,
                            input logic drop);
    exp_t e;
    exp_t got_e;
    int   k;
    logic got;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'hDEAD_BEEF;
    e.pslverr = err;
    e.prdata  = (wr || err) ? model_prdata : rdata;
    model_prdata = e.prdata;
    sb_q.push_back(e);
    @(posedge HCLK); #1;
    if (drop) begin
      PSEL = 1'b0; PENABLE = 1'b0;
    end else begin
      PENABLE = 1'b1;
    end
    check("htrans_nonseq", {30'b0, HTRANS}, 32'h2);
    check("haddr", HADDR, exp_haddr(32'h0000_0000, addr));
    check("haddr_base", HADDR_B, exp_haddr(32'h2000_0000, addr));
    check("hwrite", {31'b0, HWRITE}, {31'b0, wr});
    @(posedge HCLK); #1;
    check("htrans_idle_data", {30'b0, HTRANS}, 32'h0);
    if (wr) check("hwdata", HWDATA, wdata);
    k = 0;
    got = 1'b0;
    while (!got && k < 16) begin
      if (err) begin
        HREADY = (k >= 1);
        HRESP  = (k <= 1);
        HRDATA = 32'h5555_AAAA;
      end else begin
        HREADY = (k >= waits);
        HRESP  = 1'b0;
        HRDATA = (k >= waits) ? rdata : 32'h0BAD_0BAD;
      end
      @(posedge HCLK); #1;
      k++;
      if (PREADY) got = 1'b1;
    end
    HREADY = 1'b1; HRESP = 1'b0;
    check("pready_seen", {31'b0, got}, 32'h1);
    check("latency", 32'(k), 32'(err ? 2 : waits + 1));
    got_e = sb_q.pop_front();
    if (got) begin
      check("prdata", PRDATA, got_e.prdata);
      check("pslverr", {31'b0, PSLVERR}, {31'b0, got_e.pslverr});
    end
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge HCLK); #1;
    check("pready_pulse", {31'b0, PREADY}, 32'h0);
    check("pslverr_low", {31'b0, PSLVERR}, 32'h0);
    check("htrans_idle_after", {30'b0, HTRANS}, 32'h0);
  endtask

  initial begin
    // Reset state and constant controls
    repeat (2) @(posedge HCLK);
    #1;
    check("rst_htrans", {30'b0, HTRANS}, 32'h0);
    check("rst_haddr", HADDR, 32'h0);
    check("rst_hwdata", HWDATA, 32'h0);
    check("rst_prdata", PRDATA, 32'h0);
    check("rst_pready", {31'b0, PREADY}, 32'h0);
    check("rst_pslverr", {31'b0, PSLVERR}, 32'h0);
    check("hsize", {29'b0, HSIZE}, 32'h2);
    check("hburst", {29'b0, HBURST}, 32'h0);
    check("hprot", {28'b0, HPROT}, 32'h3);
    check("hmastlock", {31'b0, HMASTLOCK}, 32'h0);
    HRESETN = 1'b1;
    @(posedge HCLK); #1;

    // Zero-wait write
    apb_access(1'b1, 32'h0000_0040, 32'h1234_5678, 0, 1'b0, 32'h0, 1'b0);
    // Read with two wait states
    apb_access(1'b0, 32'h0000_0080, 32'h0, 2, 1'b0, 32'hCAFE_F00D, 1'b0);
    // Write with a two-cycle ERROR response
    apb_access(1'b1, 32'h0000_0044, 32'hA5A5_5A5A, 0, 1'b1, 32'h0, 1'b0);
    // Address composition with upper PADDR bits discarded
    apb_access(1'b0, 32'hFF00_1004, 32'h0, 0, 1'b0, 32'h600D_D00D, 1'b0);
    // Back-to-back reads
    apb_access(1'b0, 32'h0000_0200, 32'h0, 0, 1'b0, 32'h1111_2222, 1'b0);
    apb_access(1'b0, 32'h0000_0204, 32'h0, 1, 1'b0, 32'h3333_4444, 1'b0);
    // PSEL dropped after setup: transfer still completes
    apb_access(1'b0, 32'h0000_0300, 32'h0, 0, 1'b0, 32'h7777_8888, 1'b1);

    // Reset asserted during the data phase
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h0000_0100;
    @(posedge HCLK); #1;
    PENABLE = 1'b1;
    @(posedge HCLK); #1;
    HREADY = 1'b0;
    HRESETN = 1'b0;
    #1;
    check("rstmid_htrans", {30'b0, HTRANS}, 32'h0);
    check("rstmid_pready", {31'b0, PREADY}, 32'h0);
    check("rstmid_haddr", HADDR, 32'h0);
    check("rstmid_prdata", PRDATA, 32'h0);
    PSEL = 1'b0; PENABLE = 1'b0; HREADY = 1'b1;
    model_prdata = 32'h0;
    @(posedge HCLK); #1;
    HRESETN = 1'b1;
    @(posedge HCLK); #1;
    apb_access(1'b0, 32'h0000_0104, 32'h0, 0, 1'b0, 32'h9ABC_DEF0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
